dht_uart_formatter: RTL and testbench
=====================================

Name: dht_uart_formatter

Overview:
- Upstream of the UART transmitter; takes one DHT11 reading (integer humidity and temperature bytes) and serialises it as a fixed-format ASCII line.
- Drives the transmitter's data/send inputs and paces itself on its busy output.
- Line format: "H=hhh T=ttt" followed by CR LF, 3-digit decimal with leading zeros, 13 characters total when USE_CRLF=1.
- Sits between the DHT11 sensor interface and uart_tx in the iCE40 IoT top level.

Parameters:
- HUM_TAG, 8'h48 ("H"), ASCII tag for the humidity field.
- TEMP_TAG, 8'h54 ("T"), ASCII tag for the temperature field.
- USE_CRLF, 1, 1 = terminate with CR LF (13 chars); 0 = LF only (12 chars).

Ports:
- clk  in  1  system clock (12 MHz)
- reset_n  in  1  asynchronous, active-low reset
- rd_valid  in  1  one-cycle pulse: new reading present on rd_hum/rd_temp/rd_err
- rd_hum  in  8  humidity integer part, 0..255
- rd_temp  in  8  temperature integer part, 0..255
- rd_err  in  1  reading failed checksum (used only with DHT_ERR_MSG_EN)
- tx_busy  in  1  busy from UART transmitter
- tx_data  out  8  character to transmit
- tx_send  out  1  one-cycle send request to transmitter
- fmt_busy  out  1  high from capture until last character accepted and tx_busy low
- drop_cnt  out  8  saturating count of readings dropped while fmt_busy

Behaviour:
- Reset (async, reset_n low): tx_send=0, tx_data=8'h00, fmt_busy=0, drop_cnt=0, FSM=IDLE, converter cleared. Reset mid-line aborts the line; nothing resumes after release.
- States: IDLE, CONV, LOAD, SEND, WAIT_HI, WAIT_LO.
- IDLE:
  - rd_valid=1: latch hum/temp/err, fmt_busy<=1 next edge, go to CONV.
  - rd_valid=0: no action.
- CONV (bin2bcd8, one instance shared sequentially for hum then temp):
  - Repeated subtraction: subtract 100 while value>=100, then 10 while >=10; remainder is the ones digit.
  - At most 2+9+1 cycles per byte. Total CONV at most 24 cycles.
  - Digits stored as 4-bit BCD; ASCII = 8'h30 + digit.
- LOAD: select character index 0..MSG_LEN-1 into tx_data:
  - index 0: HUM_TAG; 1: "="; 2-4: hum hundreds/tens/ones
  - index 5: space (8'h20); 6: TEMP_TAG; 7: "="; 8-10: temp digits
  - index 11..: CR (8'h0D, only if USE_CRLF), then LF (8'h0A)
- SEND:
  - Wait until tx_busy=0, then assert tx_send for exactly one cycle with tx_data stable. Go to WAIT_HI.
  - tx_data is held stable from LOAD until the following LOAD.
- WAIT_HI: wait for tx_busy=1. The transmitter asserts busy the cycle after send.
- WAIT_LO: wait for tx_busy=0.
  - Then index+1 and LOAD, or, if last index, IDLE with fmt_busy<=0 on the same edge.
- Latency: first tx_send no later than 26 cycles after the rd_valid pulse (tx_busy idle).
- rd_valid while fmt_busy=1: reading ignored, drop_cnt+1, saturates at 255. This includes the cycle fmt_busy falls, because fmt_busy is still 1 during that cycle.
- rd_valid in IDLE with fmt_busy=0: always accepted, even the cycle right after a line completes.
- tx_send is never asserted while tx_busy=1. Never more than one send per character.
- Values above 199 (e.g. 255) are still formatted as 3 digits ("255"); no clamping.

Optional Feature:
- Macro: DHT_ERR_MSG_EN.
- Defined: if rd_err=1 at capture, CONV is skipped and the line is "ERR" + CR LF (5 chars; "ERR" + LF when USE_CRLF=0). drop_cnt behaviour is unchanged.
- Undefined: rd_err is ignored (port still present, unconnected internally); every reading is formatted numerically.

Decomposition:
- Package dht_fmt_pkg:
  - state encoding constants
  - ASCII constants: ZERO 8'h30, EQ 8'h3D, SP 8'h20, CR 8'h0D, LF 8'h0A, E 8'h45, R 8'h52
  - MSG_LEN_CRLF=13, MSG_LEN_LF=12, ERR_LEN=5
- Sub-module bin2bcd8:
  - start/done handshake, 8-bit in, three 4-bit digits out, sequential subtract.
  - Instantiated once.

Test Plan:
- hum=45, temp=23, USE_CRLF=1, bench uart_tx model (busy rises 1 cycle after send, held 10 cycles) -> chars 48 3D 30 34 35 20 54 3D 30 32 33 0D 0A, 13 sends, then fmt_busy=0.
- hum=255, temp=0 -> "H=255 T=000" + CR LF; hum=100, temp=99 -> "H=100 T=099"; check digit boundaries.
- Second rd_valid 5 cycles after the first, and again on the cycle fmt_busy falls -> both dropped, drop_cnt=2, only one line sent. rd_valid one cycle later is accepted.
- tx_busy held high for 200 cycles before first char -> tx_send stays 0 until tx_busy falls, then one pulse; no duplicate sends.
- reset_n low mid-line (after char 6) -> all outputs at reset values asynchronously; new rd_valid after release produces a complete fresh line starting with HUM_TAG.
- DHT_ERR_MSG_EN defined, rd_err=1 -> 45 52 52 0D 0A; undefined -> numeric line regardless of rd_err.

Source files
------------

// File: rtl/dht_fmt_pkg.sv
// Shared definitions for the DHT11 reading -> UART line formatter:
// FSM state encoding, ASCII constants, line lengths and a digit helper.
package dht_fmt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONV    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_WAIT_LO = 3'd5
  } fmt_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_E    = 8'h45;
  localparam logic [7:0] ASCII_R    = 8'h52;

  localparam int unsigned MSG_LEN_CRLF = 13;
  localparam int unsigned MSG_LEN_LF   = 12;
  localparam int unsigned ERR_LEN      = 5;

  // BCD digit (0..9) to its ASCII character.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/dht_uart_formatter_bin2bcd8.sv
// bin2bcd8: 8-bit binary to three BCD digits by repeated subtraction.
// A start pulse loads the value; each following cycle removes one hundred,
// else one ten, else finishes. done is high for the single cycle in which
// the remainder is below ten; the digits stay valid until the next start.
// Worst case is 2 + 9 + 1 cycles after start.
module bin2bcd8 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic       busy_r;
  logic [7:0] val_r;
  logic [3:0] hund_r;
  logic [3:0] tens_r;

  // Load on start, then peel off hundreds and tens one per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
      val_r  <= 8'd0;
      hund_r <= 4'd0;
      tens_r <= 4'd0;
    end else if (start) begin
      busy_r <= 1'b1;
      val_r  <= bin;
      hund_r <= 4'd0;
      tens_r <= 4'd0;
    end else if (busy_r) begin
      if (val_r >= 8'd100) begin
        val_r  <= val_r - 8'd100;
        hund_r <= hund_r + 4'd1;
      end else if (val_r >= 8'd10) begin
        val_r  <= val_r - 8'd10;
        tens_r <= tens_r + 4'd1;
      end else begin
        busy_r <= 1'b0;
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

  assign done     = busy_r && (val_r < 8'd10);
  assign hundreds = hund_r;
  assign tens     = tens_r;
  assign ones     = val_r[3:0];

endmodule

// File: rtl/dht_uart_formatter.sv
// dht_uart_formatter: turns one DHT11 reading into the ASCII line
// "H=hhh T=ttt" + CR LF (or LF only) and feeds it character by character
// to uart_tx, pacing on tx_busy. Readings arriving while a line is in
// flight are dropped and counted in a saturating counter.
// Optional build macro DHT_ERR_MSG_EN: a reading flagged rd_err is sent
// as "ERR" + line ending instead of numbers.
module dht_uart_formatter
  import dht_fmt_pkg::*;
#(
  parameter logic [7:0] HUM_TAG  = 8'h48,
  parameter logic [7:0] TEMP_TAG = 8'h54,
  parameter bit         USE_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rd_valid,
  input  logic [7:0] rd_hum,
  input  logic [7:0] rd_temp,
  input  logic       rd_err,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_send,
  output logic       fmt_busy,
  output logic [7:0] drop_cnt
);

  localparam logic [3:0] LAST_NUM_IDX = USE_CRLF ? 4'(MSG_LEN_CRLF - 1) : 4'(MSG_LEN_LF - 1);
  localparam logic [7:0] EOL_FIRST    = USE_CRLF ? ASCII_CR : ASCII_LF;

  fmt_state_t state_r, state_next;
  logic [3:0] idx_r, idx_next;
  logic [7:0] temp_r, temp_next;
  logic       conv_sel_r, conv_sel_next;
  logic [3:0] hum_h_r, hum_t_r, hum_o_r;
  logic [3:0] hum_h_next, hum_t_next, hum_o_next;
  logic [3:0] tmp_h_r, tmp_t_r, tmp_o_r;
  logic [3:0] tmp_h_next, tmp_t_next, tmp_o_next;
  logic [7:0] tx_data_r, tx_data_next;
  logic       tx_send_r, tx_send_next;
  logic       fmt_busy_r, fmt_busy_next;
  logic [7:0] drop_cnt_r, drop_cnt_next;

  logic       conv_start_s;
  logic [7:0] conv_bin_s;
  logic       conv_done_s;
  logic [3:0] conv_h_s, conv_t_s, conv_o_s;

  logic [7:0] num_char_s;
  logic [7:0] char_s;
  logic [3:0] last_idx_s;

`ifdef DHT_ERR_MSG_EN
  logic       err_r, err_next;
  logic [7:0] err_char_s;
`else
  logic       unused_err_s;
  assign unused_err_s = rd_err;
`endif

  bin2bcd8 u_bin2bcd8 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (conv_start_s),
    .bin      (conv_bin_s),
    .done     (conv_done_s),
    .hundreds (conv_h_s),
    .tens     (conv_t_s),
    .ones     (conv_o_s)
  );

  // Character of the numeric line at the current index.
  always_comb begin
    num_char_s = 8'h00;
    case (idx_r)
      4'd0:    num_char_s = HUM_TAG;
      4'd1:    num_char_s = ASCII_EQ;
      4'd2:    num_char_s = bcd_to_ascii(hum_h_r);
      4'd3:    num_char_s = bcd_to_ascii(hum_t_r);
      4'd4:    num_char_s = bcd_to_ascii(hum_o_r);
      4'd5:    num_char_s = ASCII_SP;
      4'd6:    num_char_s = TEMP_TAG;
      4'd7:    num_char_s = ASCII_EQ;
      4'd8:    num_char_s = bcd_to_ascii(tmp_h_r);
      4'd9:    num_char_s = bcd_to_ascii(tmp_t_r);
      4'd10:   num_char_s = bcd_to_ascii(tmp_o_r);
      4'd11:   num_char_s = EOL_FIRST;
      4'd12:   num_char_s = ASCII_LF;
      default: num_char_s = 8'h00;
    endcase
  end

`ifdef DHT_ERR_MSG_EN
  // Character of the error line at the current index.
  always_comb begin
    err_char_s = 8'h00;
    case (idx_r)
      4'd0:    err_char_s = ASCII_E;
      4'd1:    err_char_s = ASCII_R;
      4'd2:    err_char_s = ASCII_R;
      4'd3:    err_char_s = EOL_FIRST;
      4'd4:    err_char_s = ASCII_LF;
      default: err_char_s = 8'h00;
    endcase
  end

  // Pick the line type captured with the reading.
  always_comb begin
    char_s     = num_char_s;
    last_idx_s = LAST_NUM_IDX;
    if (err_r) begin
      char_s     = err_char_s;
      last_idx_s = USE_CRLF ? 4'(ERR_LEN - 1) : 4'(ERR_LEN - 2);
    end else begin
      char_s     = num_char_s;
      last_idx_s = LAST_NUM_IDX;
    end
  end
`else
  // Only the numeric line exists in this build.
  always_comb begin
    char_s     = num_char_s;
    last_idx_s = LAST_NUM_IDX;
  end
`endif

  // Next-state and next-register logic of the line sequencer.
  always_comb begin
    state_next    = state_r;
    idx_next      = idx_r;
    temp_next     = temp_r;
    conv_sel_next = conv_sel_r;
    hum_h_next    = hum_h_r;
    hum_t_next    = hum_t_r;
    hum_o_next    = hum_o_r;
    tmp_h_next    = tmp_h_r;
    tmp_t_next    = tmp_t_r;
    tmp_o_next    = tmp_o_r;
    tx_data_next  = tx_data_r;
    tx_send_next  = 1'b0;
    fmt_busy_next = fmt_busy_r;
    conv_start_s  = 1'b0;
    conv_bin_s    = temp_r;
`ifdef DHT_ERR_MSG_EN
    err_next      = err_r;
`endif

    // A reading seen while a line is in flight (including its last cycle)
    // is lost; count it without wrapping.
    if (rd_valid && fmt_busy_r) begin
      if (drop_cnt_r == 8'hFF) begin
        drop_cnt_next = drop_cnt_r;
      end else begin
        drop_cnt_next = drop_cnt_r + 8'd1;
      end
    end else begin
      drop_cnt_next = drop_cnt_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (rd_valid) begin
          temp_next     = rd_temp;
          fmt_busy_next = 1'b1;
          idx_next      = 4'd0;
          conv_sel_next = 1'b0;
`ifdef DHT_ERR_MSG_EN
          err_next = rd_err;
          if (rd_err) begin
            state_next = ST_LOAD;
          end else begin
            conv_start_s = 1'b1;
            conv_bin_s   = rd_hum;
            state_next   = ST_CONV;
          end
`else
          conv_start_s = 1'b1;
          conv_bin_s   = rd_hum;
          state_next   = ST_CONV;
`endif
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_CONV: begin
        if (conv_done_s) begin
          if (!conv_sel_r) begin
            // Humidity finished: keep its digits, reuse the converter.
            hum_h_next    = conv_h_s;
            hum_t_next    = conv_t_s;
            hum_o_next    = conv_o_s;
            conv_sel_next = 1'b1;
            conv_start_s  = 1'b1;
            conv_bin_s    = temp_r;
          end else begin
            tmp_h_next = conv_h_s;
            tmp_t_next = conv_t_s;
            tmp_o_next = conv_o_s;
            state_next = ST_LOAD;
          end
        end else begin
          state_next = ST_CONV;
        end
      end

      ST_LOAD: begin
        tx_data_next = char_s;
        state_next   = ST_SEND;
      end

      ST_SEND: begin
        if (!tx_busy) begin
          tx_send_next = 1'b1;
          state_next   = ST_WAIT_HI;
        end else begin
          state_next = ST_SEND;
        end
      end

      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_next = ST_WAIT_LO;
        end else begin
          state_next = ST_WAIT_HI;
        end
      end

      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_r == last_idx_s) begin
            fmt_busy_next = 1'b0;
            state_next    = ST_IDLE;
          end else begin
            idx_next   = idx_r + 4'd1;
            state_next = ST_LOAD;
          end
        end else begin
          state_next = ST_WAIT_LO;
        end
      end

      default: begin
        fmt_busy_next = 1'b0;
        state_next    = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any line in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= 4'd0;
      temp_r     <= 8'd0;
      conv_sel_r <= 1'b0;
      hum_h_r    <= 4'd0;
      hum_t_r    <= 4'd0;
      hum_o_r    <= 4'd0;
      tmp_h_r    <= 4'd0;
      tmp_t_r    <= 4'd0;
      tmp_o_r    <= 4'd0;
      tx_data_r  <= 8'h00;
      tx_send_r  <= 1'b0;
      fmt_busy_r <= 1'b0;
      drop_cnt_r <= 8'd0;
`ifdef DHT_ERR_MSG_EN
      err_r      <= 1'b0;
`endif
    end else begin
      state_r    <= state_next;
      idx_r      <= idx_next;
      temp_r     <= temp_next;
      conv_sel_r <= conv_sel_next;
      hum_h_r    <= hum_h_next;
      hum_t_r    <= hum_t_next;
      hum_o_r    <= hum_o_next;
      tmp_h_r    <= tmp_h_next;
      tmp_t_r    <= tmp_t_next;
      tmp_o_r    <= tmp_o_next;
      tx_data_r  <= tx_data_next;
      tx_send_r  <= tx_send_next;
      fmt_busy_r <= fmt_busy_next;
      drop_cnt_r <= drop_cnt_next;
`ifdef DHT_ERR_MSG_EN
      err_r      <= err_next;
`endif
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_send  = tx_send_r;
  assign fmt_busy = fmt_busy_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_dht_uart_formatter.sv
// Scoreboard bench for dht_uart_formatter: stimulus pushes the expected
// characters of each line into a queue, a monitor pops one per tx_send.
// A small uart_tx model raises busy the cycle after send for 10 cycles.
module tb_dht_uart_formatter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rd_valid;
  logic [7:0] rd_hum;
  logic [7:0] rd_temp;
  logic       rd_err;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       fmt_busy;
  logic [7:0] drop_cnt;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         sends_seen = 0;
  logic       prev_send = 1'b0;

  logic       model_busy = 1'b0;
  int         model_cnt  = 0;
  logic       hold_busy  = 1'b0;

  assign tx_busy = model_busy | hold_busy;

  dht_uart_formatter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_valid (rd_valid),
    .rd_hum   (rd_hum),
    .rd_temp  (rd_temp),
    .rd_err   (rd_err),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .fmt_busy (fmt_busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // uart_tx stand-in: busy from the edge that samples send, for 10 cycles.
  always @(posedge clk) begin
    if (tx_send === 1'b1) begin
      model_busy <= 1'b1;
      model_cnt  <= 10;
    end else if (model_cnt > 1) begin
      model_cnt <= model_cnt - 1;
    end else begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end
  end

  // Monitor: every send must be a single-cycle pulse, while idle, matching the queue head.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset_n === 1'b1) begin
      if (tx_send === 1'b1) begin
        sends_seen++;
        check("send_while_busy", 32'(tx_busy), 32'd0);
        check("send_pulse_width", 32'(prev_send), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_send", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("tx_char", 32'(tx_data), 32'(e));
        end
      end
      prev_send = tx_send;
    end else begin
      prev_send = 1'b0;
    end
  end

  task automatic push_str(input string s, input bit eol);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (eol) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic pulse(input logic [7:0] h, input logic [7:0] t, input logic e);
    @(negedge clk);
    rd_hum   = h;
    rd_temp  = t;
    rd_err   = e;
    rd_valid = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int start, input int expect_sends);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fmt_busy === 1'b0 && tx_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("line_complete_in_time", 32'(ok), 32'd1);
    check("send_count", 32'(sends_seen - start), 32'(expect_sends));
    exp_q.delete();
  endtask

  task automatic run_line(input logic [7:0] h, input logic [7:0] t, input logic e, input string s);
    int start;
    start = sends_seen;
    push_str(s, 1'b1);
    pulse(h, t, e);
    check("fmt_busy_after_capture", 32'(fmt_busy), 32'd1);
    wait_idle(start, s.len() + 2);
  endtask

  initial begin
    int  start;
    int  lat;
    bit  ok;
    reset_n  = 1'b0;
    rd_valid = 1'b0;
    rd_hum   = 8'd0;
    rd_temp  = 8'd0;
    rd_err   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx_send", 32'(tx_send), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'h00);
    check("reset_fmt_busy", 32'(fmt_busy), 32'd0);
    check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic line and digit boundaries.
    run_line(8'd45, 8'd23, 1'b0, "H=045 T=023");
    run_line(8'd255, 8'd0, 1'b0, "H=255 T=000");
    run_line(8'd100, 8'd99, 1'b0, "H=100 T=099");
    run_line(8'd9, 8'd10, 1'b0, "H=009 T=010");

    // Slowest conversion: first send must appear within 26 cycles.
    start = sends_seen;
    push_str("H=199 T=199", 1'b1);
    @(negedge clk);
    rd_hum = 8'd199; rd_temp = 8'd199; rd_err = 1'b0; rd_valid = 1'b1;
    @(posedge clk);
    #1 rd_valid = 1'b0;
    lat = 0;
    while (tx_send !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    check("first_send_latency_le_26", 32'(lat <= 26), 32'd1);
    wait_idle(start, 13);

    // Drops: one mid-line, one on the cycle fmt_busy falls; next cycle accepted.
    start = sends_seen;
    push_str("H=045 T=023", 1'b1);
    pulse(8'd45, 8'd23, 1'b0);
    repeat (3) @(negedge clk);
    pulse(8'd11, 8'd22, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    for (int i = 0; i < 50 && ok; i++) begin
      if (tx_busy === 1'b1) break;
      @(negedge clk);
    end
    for (int i = 0; i < 50 && ok; i++) begin
      if (tx_busy === 1'b0) break;
      @(negedge clk);
    end
    check("drop_test_reached_end", 32'(ok), 32'd1);
    check("drop_fmt_busy_last_cycle", 32'(fmt_busy), 32'd1);
    rd_hum = 8'd33; rd_temp = 8'd44; rd_valid = 1'b1;
    @(negedge clk);
    check("drop_fmt_busy_fell", 32'(fmt_busy), 32'd0);
    check("drop_cnt_two", 32'(drop_cnt), 32'd2);
    check("drop_one_line_sent", 32'(sends_seen - start), 32'd13);
    start = sends_seen;
    push_str("H=100 T=099", 1'b1);
    rd_hum = 8'd100; rd_temp = 8'd99;
    @(negedge clk);
    rd_valid = 1'b0;
    check("accept_after_fall", 32'(fmt_busy), 32'd1);
    wait_idle(start, 13);
    check("drop_cnt_kept", 32'(drop_cnt), 32'd2);

    // Transmitter busy for 200 cycles before the first character.
    start = sends_seen;
    hold_busy = 1'b1;
    push_str("H=012 T=034", 1'b1);
    pulse(8'd12, 8'd34, 1'b0);
    repeat (200) @(negedge clk);
    check("no_send_while_held", 32'(sends_seen - start), 32'd0);
    hold_busy = 1'b0;
    wait_idle(start, 13);

    // Reset after the seventh character aborts the line.
    start = sends_seen;
    push_str("H=067 T", 1'b0);
    pulse(8'd67, 8'd89, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sends_seen - start >= 7) begin ok = 1'b1; break; end
    end
    check("reset_test_reached_char6", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_tx_send", 32'(tx_send), 32'd0);
    check("async_reset_tx_data", 32'(tx_data), 32'h00);
    check("async_reset_fmt_busy", 32'(fmt_busy), 32'd0);
    check("async_reset_drop_cnt", 32'(drop_cnt), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_resume_after_reset", 32'(sends_seen - start), 32'd7);
    check("reset_line_chars_consumed", 32'(exp_q.size()), 32'd0);
    run_line(8'd67, 8'd89, 1'b0, "H=067 T=089");

    // Checksum-failed reading.
`ifdef DHT_ERR_MSG_EN
    run_line(8'd45, 8'd23, 1'b1, "ERR");
`else
    run_line(8'd45, 8'd23, 1'b1, "H=045 T=023");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
